// File: rtl/piezo_melody_scheduler.sv
// Arbitrates four vending-machine melody sources onto one piezo tone generator:
// fixed priority, preemption by higher sources, one pending slot per source.
module piezo_melody_scheduler #(
    parameter int NOTE_TICKS = 5_000_000,
    parameter int GAP_TICKS  = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       mute,
    output logic [3:0] note_state,
    output logic [2:0] note_played,
    output logic [3:0] grant,
    output logic       busy,
    output logic       done
);
    localparam int MAX_TICKS = (NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS;
    localparam int CW = $clog2(MAX_TICKS + 1);
    localparam logic [CW-1:0] NOTE_LOAD = CW'(NOTE_TICKS - 1);
    localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_TICKS - 1);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NOTE = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t        state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic [3:0]    grant_r, grant_s;
    logic [3:0]    pend_r, pend_s;
    logic [3:0]    note_r, note_s;
    logic [2:0]    idx_r, idx_s;
    logic          busy_r, busy_s;
    logic          done_r, done_s;
    logic [3:0]    pool_s, pool_win_s, req_win_s, launch_grant_s;
    logic          preempt_s, last_s, launch_s;

    function automatic logic [3:0] pick_highest(input logic [3:0] v);
        if (v[3])      return 4'b1000;
        else if (v[2]) return 4'b0100;
        else if (v[1]) return 4'b0010;
        else if (v[0]) return 4'b0001;
        else           return 4'b0000;
    endfunction

    // Sources strictly above a one-hot grant; empty when idle.
    function automatic logic [3:0] above_mask(input logic [3:0] g);
        return ~(g | (g - 4'd1));
    endfunction

    function automatic logic [1:0] src_index(input logic [3:0] g);
        case (g)
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [2:0] last_index(input logic [1:0] s);
        case (s)
            2'd0:    return 3'd1;
            2'd1:    return 3'd3;
            2'd2:    return 3'd7;
            2'd3:    return 3'd2;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic [3:0] rom_note(input logic [1:0] s, input logic [2:0] i);
        case (s)
            2'd0: return (i == 3'd0) ? 4'd5 : 4'd8;
            2'd1: begin
                case (i)
                    3'd0:    return 4'd1;
                    3'd1:    return 4'd3;
                    3'd2:    return 4'd5;
                    default: return 4'd8;
                endcase
            end
            2'd2:    return {1'b0, i} + 4'd1;
            2'd3:    return (i == 3'd1) ? 4'd1 : 4'd8;
            default: return 4'd0;
        endcase
    endfunction

    // Next-state, arbitration and registered-output decode.
    always_comb begin
        state_s        = state_r;
        cnt_s          = cnt_r;
        grant_s        = grant_r;
        idx_s          = idx_r;
        pend_s         = pend_r;
        launch_s       = 1'b0;
        launch_grant_s = 4'b0000;
        pool_s         = pend_r | req;
        pool_win_s     = pick_highest(pool_s);
        req_win_s      = pick_highest(req);
        preempt_s      = |(req & above_mask(grant_r));
        last_s         = (idx_r == last_index(src_index(grant_r)));

        case (state_r)
            ST_IDLE: begin
                if (|pool_s) begin
                    launch_s       = 1'b1;
                    launch_grant_s = pool_win_s;
                end else begin
                    launch_s = 1'b0;
                end
            end
            ST_NOTE: begin
                if (preempt_s) begin
                    launch_s       = 1'b1;
                    launch_grant_s = req_win_s;
                end else if (cnt_r == CNT_ZERO) begin
                    state_s = ST_GAP;
                    cnt_s   = GAP_LOAD;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            ST_GAP: begin
                // Completion takes precedence: a same-cycle req simply joins the pool.
                if ((cnt_r == CNT_ZERO) && last_s) begin
                    if (|pool_s) begin
                        launch_s       = 1'b1;
                        launch_grant_s = pool_win_s;
                    end else begin
                        state_s = ST_IDLE;
                        grant_s = 4'b0000;
                        idx_s   = 3'd0;
                        cnt_s   = CNT_ZERO;
                    end
                end else if (preempt_s) begin
                    launch_s       = 1'b1;
                    launch_grant_s = req_win_s;
                end else if (cnt_r == CNT_ZERO) begin
                    state_s = ST_NOTE;
                    cnt_s   = NOTE_LOAD;
                    idx_s   = idx_r + 3'd1;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                grant_s = 4'b0000;
                idx_s   = 3'd0;
                cnt_s   = CNT_ZERO;
            end
        endcase

        if (launch_s) begin
            state_s = ST_NOTE;
            grant_s = launch_grant_s;
            idx_s   = 3'd0;
            cnt_s   = NOTE_LOAD;
            pend_s  = pool_s & ~launch_grant_s;
        end else begin
            pend_s = (state_s == ST_IDLE) ? 4'b0000 : pool_s;
        end

        note_s = (state_s == ST_NOTE) ? rom_note(src_index(grant_s), idx_s) : 4'd0;
        busy_s = (state_s != ST_IDLE);
        done_s = (state_s == ST_GAP) && (cnt_s == CNT_ZERO) &&
                 (idx_s == last_index(src_index(grant_s)));
    end

    // State, counter, pending set and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            grant_r <= 4'b0000;
            pend_r  <= 4'b0000;
            idx_r   <= 3'd0;
            note_r  <= 4'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            grant_r <= grant_s;
            pend_r  <= pend_s;
            idx_r   <= idx_s;
            note_r  <= note_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    assign note_state  = mute ? 4'd0 : note_r;
    assign note_played = idx_r;
    assign grant       = grant_r;
    assign busy        = busy_r;
    assign done        = done_r;
endmodule

// File: tb/tb_piezo_melody_scheduler.sv
// Bench for piezo_melody_scheduler: constant vector tables, directed corner
// sequences and random requests checked against an elapsed-time melody model.
module tb_piezo_melody_scheduler;
    localparam int NT  = 4;
    localparam int GT  = 2;
    localparam int PER = NT + GT;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       mute;
    logic [3:0] note_state;
    logic [2:0] note_played;
    logic [3:0] grant;
    logic       busy;
    logic       done;

    piezo_melody_scheduler #(.NOTE_TICKS(NT), .GAP_TICKS(GT)) dut (
        .clk(clk), .rst(rst), .req(req), .mute(mute),
        .note_state(note_state), .note_played(note_played),
        .grant(grant), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic       mute;
        logic [3:0] note;
        logic [2:0] played;
        logic [3:0] grant;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t        vecs[28];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    logic [12:0] obs;

    // Reference: which source plays and how many cycles since its first note.
    int         m_active;
    int         m_elapsed;
    logic [3:0] m_pend;
    int         mlen[4];
    int         mrom[4][8];

    function automatic int highest(input logic [3:0] v);
        for (int i = 3; i >= 0; i--) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [12:0] pk(input logic [3:0] n, input logic [2:0] p,
                                       input logic [3:0] g, input logic b, input logic d);
        return {n, p, g, b, d};
    endfunction

    function automatic void model_step(input logic [3:0] r, input logic rs);
        int         h;
        logic [3:0] pool;
        logic [3:0] onehot;
        bit         finishing;
        if (rs) begin
            m_active  = -1;
            m_elapsed = 0;
            m_pend    = 4'b0000;
        end else begin
            finishing = (m_active >= 0) && (m_elapsed == mlen[m_active] * PER - 1);
            if (m_active < 0 || finishing) begin
                pool = m_pend | r;
                h = highest(pool);
                if (h >= 0) begin
                    onehot    = 4'b0001 << h;
                    m_active  = h;
                    m_elapsed = 0;
                    m_pend    = pool & ~onehot;
                end else begin
                    m_active = -1;
                    m_pend   = 4'b0000;
                end
            end else if (highest(r) > m_active) begin
                h         = highest(r);
                onehot    = 4'b0001 << h;
                m_active  = h;
                m_elapsed = 0;
                m_pend    = (m_pend | r) & ~onehot;
            end else begin
                m_elapsed = m_elapsed + 1;
                m_pend    = m_pend | r;
            end
        end
    endfunction

    function automatic logic [12:0] model_out(input logic m);
        int         idx;
        int         ph;
        logic [3:0] nt;
        logic [3:0] g;
        logic       dn;
        if (m_active < 0) return 13'd0;
        idx = m_elapsed / PER;
        ph  = m_elapsed % PER;
        nt  = (ph < NT && !m) ? 4'(mrom[m_active][idx]) : 4'd0;
        g   = 4'b0001 << m_active;
        dn  = (m_elapsed == mlen[m_active] * PER - 1);
        return pk(nt, 3'(idx), g, 1'b1, dn);
    endfunction

    task automatic check(input string nm, input logic [12:0] act, input logic [12:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %h expected %h ({note,played,grant,busy,done})",
                     nm, cyc, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare against the model, then clock both.
    task automatic cycle(input logic [3:0] r, input logic m, input logic rs);
        req  = r;
        mute = m;
        rst  = rs;
        #1;
        obs = {note_state, note_played, grant, busy, done};
        check("model", obs, model_out(m));
        @(posedge clk);
        model_step(r, rs);
        cyc++;
        #1;
    endtask

    initial begin
        int ndone;
        int nbusy;
        logic [3:0] r;

        mlen = '{2, 4, 8, 3};
        mrom = '{'{5, 8, 0, 0, 0, 0, 0, 0}, '{1, 3, 5, 8, 0, 0, 0, 0},
                 '{1, 2, 3, 4, 5, 6, 7, 8}, '{8, 1, 8, 0, 0, 0, 0, 0}};

        // Coin melody, then the same melody with mute held over cycles 2-8.
        vecs[0] = '{4'b0001, 1'b0, 4'd0, 3'd0, 4'b0000, 1'b0, 1'b0};
        for (int i = 1; i <= 4; i++)  vecs[i] = '{4'b0000, 1'b0, 4'd5, 3'd0, 4'b0001, 1'b1, 1'b0};
        for (int i = 5; i <= 6; i++)  vecs[i] = '{4'b0000, 1'b0, 4'd0, 3'd0, 4'b0001, 1'b1, 1'b0};
        for (int i = 7; i <= 10; i++) vecs[i] = '{4'b0000, 1'b0, 4'd8, 3'd1, 4'b0001, 1'b1, 1'b0};
        vecs[11] = '{4'b0000, 1'b0, 4'd0, 3'd1, 4'b0001, 1'b1, 1'b0};
        vecs[12] = '{4'b0000, 1'b0, 4'd0, 3'd1, 4'b0001, 1'b1, 1'b1};
        vecs[13] = '{4'b0000, 1'b0, 4'd0, 3'd0, 4'b0000, 1'b0, 1'b0};
        for (int i = 0; i < 14; i++) begin
            vecs[14 + i] = vecs[i];
            if (i >= 2 && i <= 8) begin
                vecs[14 + i].mute = 1'b1;
                vecs[14 + i].note = 4'd0;
            end
        end

        rst  = 1'b1;
        req  = 4'b0000;
        mute = 1'b0;
        @(posedge clk);
        model_step(4'b0000, 1'b1);
        #1;
        cycle(4'b0000, 1'b0, 1'b1);
        cycle(4'b0000, 1'b0, 1'b0);
        check("reset_state", obs, 13'd0);

        for (int i = 0; i < 28; i++) begin
            cycle(vecs[i].req, vecs[i].mute, 1'b0);
            check("vec", obs, pk(vecs[i].note, vecs[i].played, vecs[i].grant,
                                 vecs[i].busy, vecs[i].done));
        end

        // Two requests at once: purchase first, coin back-to-back.
        for (int c = 0; c < 40; c++) begin
            cycle((c == 0) ? 4'b0011 : 4'b0000, 1'b0, 1'b0);
            if (c == 1)  check("dual_first", obs, pk(4'd1, 3'd0, 4'b0010, 1'b1, 1'b0));
            if (c == 24) check("dual_done", obs, pk(4'd0, 3'd3, 4'b0010, 1'b1, 1'b1));
            if (c == 25) check("dual_next", obs, pk(4'd5, 3'd0, 4'b0001, 1'b1, 1'b0));
            if (c == 37) check("dual_idle", obs, 13'd0);
        end

        // Error preempts admin; admin is discarded.
        ndone = 0;
        for (int c = 0; c < 36; c++) begin
            r = (c == 0) ? 4'b0100 : ((c == 10) ? 4'b1000 : 4'b0000);
            cycle(r, 1'b0, 1'b0);
            ndone += int'(obs[0]);
            if (c == 11) check("preempt", obs, pk(4'd8, 3'd0, 4'b1000, 1'b1, 1'b0));
            if (c == 28) check("preempt_done", obs, pk(4'd0, 3'd2, 4'b1000, 1'b1, 1'b1));
            if (c == 29) check("preempt_idle", obs, 13'd0);
        end
        check("preempt_dones", 13'(ndone), 13'd1);

        // Purchase replay queued ahead of a lower coin request.
        ndone = 0;
        for (int c = 0; c < 66; c++) begin
            r = (c == 0 || c == 8) ? 4'b0010 : ((c == 5) ? 4'b0001 : 4'b0000);
            cycle(r, 1'b0, 1'b0);
            ndone += int'(obs[0]);
            if (c == 25) check("replay", obs, pk(4'd1, 3'd0, 4'b0010, 1'b1, 1'b0));
            if (c == 49) check("queued_coin", obs, pk(4'd5, 3'd0, 4'b0001, 1'b1, 1'b0));
            if (c == 61) check("queue_idle", obs, 13'd0);
        end
        check("queue_dones", 13'(ndone), 13'd3);

        // Reset mid-melody with coin pending.
        nbusy = 0;
        for (int c = 0; c < 30; c++) begin
            cycle((c == 0) ? 4'b0011 : 4'b0000, 1'b0, (c == 6));
            if (c == 7) check("rst_silence", obs, 13'd0);
            if (c >= 8) nbusy += int'(obs[1]) + int'(obs[0]);
        end
        check("rst_no_restart", 13'(nbusy), 13'd0);

        // Random requests, mute and occasional reset.
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 4; b++) r[b] = ($urandom_range(0, 31) == 0);
            cycle(r, ($urandom_range(0, 15) == 0), ($urandom_range(0, 999) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
